// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-enabled data memory with a reset clear sweep and fixed-latency in-order responses
module data_memory_ctrl #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          READ_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);
    localparam int BW = DATA_W / 8;
    localparam int AB = $clog2(BW);
    localparam int IW = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * BW);

    typedef enum logic {CLEAR, RUN} stateType;

    stateType          state, nextState;
    logic [IW-1:0]     clrPtr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [31:0]       off;
    logic [IW-1:0]     wordIdx;
    logic              addrErr, accept;
    logic              pipeValid [READ_LAT];
    logic [DATA_W-1:0] pipeData  [READ_LAT];
    logic              pipeErr   [READ_LAT];

    // Out-of-range offsets are flagged rather than wrapped, so no request aliases into the array.
    assign off       = req_addr - BASE_ADDR;
    assign wordIdx   = IW'(off >> AB);
    assign addrErr   = (req_addr < BASE_ADDR) || (off >= SPAN) || ((off & 32'(BW - 1)) != 32'd0);
    assign accept    = req_valid && req_ready && !rst;
    assign rsp_valid = pipeValid[READ_LAT-1];
    assign rsp_rdata = pipeData[READ_LAT-1];
    assign rsp_err   = pipeErr[READ_LAT-1];

    // State register; the clear pointer advances one word per cycle while sweeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state <= nextState;
            if (state == CLEAR) clrPtr <= clrPtr + 1'b1;
        end
    end

    // Sweep ends after the last word is cleared; RUN is only left through reset.
    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        if (state == CLEAR && clrPtr == IW'(DEPTH - 1)) nextState = RUN;
        if (state == RUN) begin
            req_ready = 1'b1;
            init_done = 1'b1;
        end
    end

    // Array update: zero one word per cycle in CLEAR, byte-lane writes for error-free requests in RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clrPtr] <= '0;
        else if (accept && req_we && !addrErr)
            for (int b = 0; b < BW; b++)
                if (req_be[b]) mem[wordIdx][8*b +: 8] <= req_wdata[8*b +: 8];
    end

    // Response pipeline of READ_LAT stages; idle slots carry zeros so outputs are clean when not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipeValid[i] <= 1'b0;
                pipeData[i]  <= '0;
                pipeErr[i]   <= 1'b0;
            end
        end else begin
            pipeValid[0] <= accept;
            pipeErr[0]   <= accept && addrErr;
            pipeData[0]  <= (accept && !req_we && !addrErr) ? mem[wordIdx] : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeData[i]  <= pipeData[i-1];
                pipeErr[i]   <= pipeErr[i-1];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed checks of data_memory_ctrl at read latencies 2 (main), 1 and 4
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rdy  [3];
    logic        rv   [3];
    logic [31:0] rd   [3];
    logic        re   [3];
    logic        done [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Index 0: READ_LAT=2, index 1: READ_LAT=1, index 2: READ_LAT=4; all share one request stream.
    data_memory_ctrl #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_err(re[0]), .init_done(done[0]));
    data_memory_ctrl #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_err(re[1]), .init_done(done[1]));
    data_memory_ctrl #(.READ_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[2]),
        .rsp_rdata(rd[2]), .rsp_err(re[2]), .init_done(done[2]));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    // One request on the main instance, returning its response and measured latency (99 = timeout).
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
        drive(1'b1, we, a, d, be);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        lat = 1;
        while (!rv[0] && lat < 10) begin
            step();
            lat++;
        end
        if (!rv[0]) lat = 99;
        rdata = rd[0];
        err   = re[0];
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        total++;
        if ({rdy[0], done[0], rv[0], re[0]} !== 4'b0 || rd[0] !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b done=%b valid=%b err=%b rdata=%h, want all 0", rdy[0], done[0], rv[0], re[0], rd[0]);
        end
        rst = 1'b0;
        cnt = 0;
        while (!done[0] && cnt < 200) begin
            step();
            cnt++;
        end
        total++;
        if (cnt !== 64) begin
            bad++;
            $display("FAIL init_latency: got %0d cycles, want 64", cnt);
        end
        total++;
        if (rdy[0] !== 1'b1 || done[1] !== 1'b1 || done[2] !== 1'b1) begin
            bad++;
            $display("FAIL run_ready: ready=%b done1=%b done4=%b, want 1 1 1", rdy[0], done[1], done[2]);
        end
    endtask

    task automatic test_clear_reads;
        logic [31:0] r;
        logic e;
        int lat;
        for (int i = 0; i < 64; i++) begin
            xfer(1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'h0, r, e, lat);
            total++;
            if (lat !== 2 || r !== 32'h0 || e !== 1'b0) begin
                bad++;
                $display("FAIL clear_read[%0d]: lat=%0d rdata=%h err=%b, want 2 00000000 0", i, lat, r, e);
            end
        end
    endtask

    task automatic test_write_read;
        drive(1'b1, 1'b1, 32'h408, 32'hDEADBEEF, 4'hF);
        step();
        drive(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        total++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'h0 || re[0] !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp: valid=%b rdata=%h err=%b, want 1 00000000 0", rv[0], rd[0], re[0]);
        end
        step();
        total++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'hDEADBEEF || re[0] !== 1'b0) begin
            bad++;
            $display("FAIL raw_read: valid=%b rdata=%h err=%b, want 1 deadbeef 0", rv[0], rd[0], re[0]);
        end
        step();
        total++;
        if (rv[0] !== 1'b0 || rd[0] !== 32'h0 || re[0] !== 1'b0) begin
            bad++;
            $display("FAIL rsp_pulse: valid=%b rdata=%h err=%b, want 0 00000000 0", rv[0], rd[0], re[0]);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] r;
        logic e;
        int lat;
        xfer(1'b1, 32'h408, 32'h11223344, 4'b0101, r, e, lat);
        total++;
        if (lat !== 2 || r !== 32'h0 || e !== 1'b0) begin
            bad++;
            $display("FAIL be_write: lat=%0d rdata=%h err=%b, want 2 00000000 0", lat, r, e);
        end
        xfer(1'b0, 32'h408, 32'h0, 4'h0, r, e, lat);
        total++;
        if (lat !== 2 || r !== 32'hDE22BE44 || e !== 1'b0) begin
            bad++;
            $display("FAIL be_read: lat=%0d rdata=%h err=%b, want 2 de22be44 0", lat, r, e);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [3] = '{32'h3FC, 32'h500, 32'h402};
        logic [31:0] r;
        logic e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, addrs[i], 32'h0, 4'h0, r, e, lat);
            total++;
            if (lat !== 2 || r !== 32'h0 || e !== 1'b1) begin
                bad++;
                $display("FAIL err_read[%h]: lat=%0d rdata=%h err=%b, want 2 00000000 1", addrs[i], lat, r, e);
            end
        end
        xfer(1'b1, 32'h500, 32'hFFFFFFFF, 4'hF, r, e, lat);
        total++;
        if (lat !== 2 || r !== 32'h0 || e !== 1'b1) begin
            bad++;
            $display("FAIL err_write: lat=%0d rdata=%h err=%b, want 2 00000000 1", lat, r, e);
        end
        xfer(1'b0, 32'h400, 32'h0, 4'h0, r, e, lat);
        total++;
        if (lat !== 2 || r !== 32'h0 || e !== 1'b0) begin
            bad++;
            $display("FAIL no_alias: lat=%0d rdata=%h err=%b, want 2 00000000 0", lat, r, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic e;
        int lat;
        int cnt [3] = '{0, 0, 0};
        int first [3] = '{-1, -1, -1};
        int expFirst [3] = '{1, 0, 3};
        int expLat [3] = '{2, 1, 4};
        bit ok [3] = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) xfer(1'b1, 32'h400 + 32'(4 * i), 32'(i), 4'hF, r, e, lat);
        repeat (6) step();
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drive(1'b1, 1'b0, 32'h400 + 32'(4 * c), 32'h0, 4'h0);
            else drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            step();
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    if (cnt[k] == 0) first[k] = c;
                    if (rd[k] !== 32'(cnt[k]) || re[k] !== 1'b0 || c != first[k] + cnt[k]) ok[k] = 1'b0;
                    cnt[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cnt[k] !== 8 || first[k] !== expFirst[k]) begin
                bad++;
                $display("FAIL b2b_timing lat%0d: count=%0d first=%0d, want 8 %0d", expLat[k], cnt[k], first[k], expFirst[k]);
            end
            total++;
            if (ok[k] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_order lat%0d: order_ok=%b, want 1 (data 0..7, consecutive)", expLat[k], ok[k]);
            end
        end
    endtask

    task automatic test_reset_restart;
        int cnt;
        int seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        while (!done[0] && cnt < 200) begin
            step();
            cnt++;
        end
        total++;
        if (cnt !== 64) begin
            bad++;
            $display("FAIL restart_latency: got %0d cycles, want 64", cnt);
        end
        drive(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        step();
        drive(1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) if (rv[k]) seen++;
            step();
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_on_reset: saw %0d responses after reset, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
